// File: rtl/stage_mem.sv
// Memory-access pipeline stage and MEM/WB register with a req/ack data-bus handshake.
// Optional LL/SC support (llbit) is enabled by defining STAGE_MEM_LLSC_EN.
module stage_mem #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MEMOP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [31:0]       wdata,
  input  logic [MEMOP_W-1:0] mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              we_hilo,
  input  logic [31:0]       hi,
  input  logic [31:0]       lo,
  output logic              we_o,
  output logic [4:0]        waddr_o,
  output logic [31:0]       wdata_o,
  output logic              we_hilo_o,
  output logic [31:0]       hi_o,
  output logic [31:0]       lo_o,
  output logic              stall_req,
  output logic              addr_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_sel,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  localparam logic [MEMOP_W-1:0] OpLb  = MEMOP_W'(1);
  localparam logic [MEMOP_W-1:0] OpLbu = MEMOP_W'(2);
  localparam logic [MEMOP_W-1:0] OpLh  = MEMOP_W'(3);
  localparam logic [MEMOP_W-1:0] OpLhu = MEMOP_W'(4);
  localparam logic [MEMOP_W-1:0] OpLw  = MEMOP_W'(5);
  localparam logic [MEMOP_W-1:0] OpSb  = MEMOP_W'(6);
  localparam logic [MEMOP_W-1:0] OpSh  = MEMOP_W'(7);
  localparam logic [MEMOP_W-1:0] OpSw  = MEMOP_W'(8);
`ifdef STAGE_MEM_LLSC_EN
  localparam logic [MEMOP_W-1:0] OpLl  = MEMOP_W'(9);
  localparam logic [MEMOP_W-1:0] OpSc  = MEMOP_W'(10);
`endif

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_waddr_q, wb_waddr_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;
  logic        wb_we_hilo_q, wb_we_hilo_d;
  logic [31:0] wb_hi_q, wb_hi_d;
  logic [31:0] wb_lo_q, wb_lo_d;
  logic        addr_err_q, addr_err_d;

  logic        is_load, is_store, is_signed;
  logic [1:0]  size;
  logic        misaligned, sc_fail, start;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

`ifdef STAGE_MEM_LLSC_EN
  logic        is_ll, is_sc;
  logic        llbit_q, llbit_d;
`endif

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    size      = SzWord;
`ifdef STAGE_MEM_LLSC_EN
    is_ll     = 1'b0;
    is_sc     = 1'b0;
`endif
    case (mem_op)
      OpLb:  begin is_load = 1'b1; is_signed = 1'b1; size = SzByte; end
      OpLbu: begin is_load = 1'b1; size = SzByte; end
      OpLh:  begin is_load = 1'b1; is_signed = 1'b1; size = SzHalf; end
      OpLhu: begin is_load = 1'b1; size = SzHalf; end
      OpLw:  begin is_load = 1'b1; end
      OpSb:  begin is_store = 1'b1; size = SzByte; end
      OpSh:  begin is_store = 1'b1; size = SzHalf; end
      OpSw:  begin is_store = 1'b1; end
`ifdef STAGE_MEM_LLSC_EN
      OpLl:  begin is_load = 1'b1; is_ll = 1'b1; end
      OpSc:  begin is_store = 1'b1; is_sc = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    if (is_load || is_store) begin
      if (size == SzHalf) misaligned = mem_addr[0];
      if (size == SzWord) misaligned = (mem_addr[1:0] != 2'b00);
    end
`ifdef STAGE_MEM_LLSC_EN
    sc_fail = is_sc && !llbit_q;
`else
    sc_fail = 1'b0;
`endif
    start = (is_load || is_store) && !misaligned && !sc_fail;
  end

  // Bus side is combinational from the EX inputs; the stall keeps them stable while busy.
  always_comb begin
    bus_addr  = {mem_addr[ADDR_W-1:2], 2'b00};
    bus_we    = is_store;
    bus_sel   = 4'b1111;
    bus_wdata = wdata;
    case (size)
      SzByte: begin
        bus_wdata = {4{wdata[7:0]}};
        case (mem_addr[1:0])
          2'd0:    bus_sel = 4'b1000;
          2'd1:    bus_sel = 4'b0100;
          2'd2:    bus_sel = 4'b0010;
          default: bus_sel = 4'b0001;
        endcase
      end
      SzHalf: begin
        bus_wdata = {2{wdata[15:0]}};
        bus_sel   = mem_addr[1] ? 4'b0011 : 4'b1100;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (mem_addr[1:0])
      2'd0:    ld_byte = bus_rdata[31:24];
      2'd1:    ld_byte = bus_rdata[23:16];
      2'd2:    ld_byte = bus_rdata[15:8];
      default: ld_byte = bus_rdata[7:0];
    endcase
    ld_half = mem_addr[1] ? bus_rdata[15:0] : bus_rdata[31:16];
    case (size)
      SzByte:  load_data = {{24{is_signed & ld_byte[7]}}, ld_byte};
      SzHalf:  load_data = {{16{is_signed & ld_half[15]}}, ld_half};
      default: load_data = bus_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    bus_req      = 1'b0;
    stall_req    = 1'b0;
    wb_we_d      = we;
    wb_waddr_d   = waddr;
    wb_wdata_d   = wdata;
    wb_we_hilo_d = we_hilo;
    wb_hi_d      = hi;
    wb_lo_d      = lo;
    addr_err_d   = 1'b0;
`ifdef STAGE_MEM_LLSC_EN
    llbit_d      = llbit_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (misaligned) begin
          wb_we_d      = 1'b0;
          wb_we_hilo_d = 1'b0;
          addr_err_d   = 1'b1;
        end else if (sc_fail) begin
          wb_wdata_d = 32'd0;
        end else if (start) begin
          bus_req      = 1'b1;
          stall_req    = 1'b1;
          wb_we_d      = 1'b0;
          wb_we_hilo_d = 1'b0;
          state_d      = StBusy;
        end
      end
      StBusy: begin
        bus_req = 1'b1;
        if (bus_ack) begin
          state_d = StIdle;
          if (is_load) wb_wdata_d = load_data;
          if (is_store) wb_we_d = 1'b0;
`ifdef STAGE_MEM_LLSC_EN
          if (is_ll) llbit_d = 1'b1;
          if (is_store) llbit_d = 1'b0;
          if (is_sc) begin
            wb_we_d    = we;
            wb_wdata_d = 32'd1;
          end
`endif
        end else begin
          stall_req    = 1'b1;
          wb_we_d      = 1'b0;
          wb_we_hilo_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!rst) begin
      bus_req   = 1'b0;
      stall_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      wb_we_q      <= 1'b0;
      wb_waddr_q   <= 5'd0;
      wb_wdata_q   <= 32'd0;
      wb_we_hilo_q <= 1'b0;
      wb_hi_q      <= 32'd0;
      wb_lo_q      <= 32'd0;
      addr_err_q   <= 1'b0;
`ifdef STAGE_MEM_LLSC_EN
      llbit_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wb_we_q      <= wb_we_d;
      wb_waddr_q   <= wb_waddr_d;
      wb_wdata_q   <= wb_wdata_d;
      wb_we_hilo_q <= wb_we_hilo_d;
      wb_hi_q      <= wb_hi_d;
      wb_lo_q      <= wb_lo_d;
      addr_err_q   <= addr_err_d;
`ifdef STAGE_MEM_LLSC_EN
      llbit_q      <= llbit_d;
`endif
    end
  end

  assign we_o      = wb_we_q;
  assign waddr_o   = wb_waddr_q;
  assign wdata_o   = wb_wdata_q;
  assign we_hilo_o = wb_we_hilo_q;
  assign hi_o      = wb_hi_q;
  assign lo_o      = wb_lo_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_stage_mem.sv
// Randomized self-checking bench for stage_mem against a behavioural model of the op table.
module tb_stage_mem;

`ifdef STAGE_MEM_LLSC_EN
  localparam bit LlscEn = 1'b1;
`else
  localparam bit LlscEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic        we_hilo;
  logic [31:0] hi, lo;
  logic        we_o, we_hilo_o, stall_req, addr_err, bus_req, bus_we, bus_ack;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o, hi_o, lo_o, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_sel;

  int errors = 0;
  int checks = 0;
  bit llbit_m = 1'b0;

  always #5 clk = ~clk;

  stage_mem #(.ADDR_W(32), .MEMOP_W(4)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .mem_op(mem_op),
    .mem_addr(mem_addr), .we_hilo(we_hilo), .hi(hi), .lo(lo), .we_o(we_o),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .we_hilo_o(we_hilo_o), .hi_o(hi_o), .lo_o(lo_o),
    .stall_req(stall_req), .addr_err(addr_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one EX op, plays the bus for `delay` extra busy cycles, then checks the WB result.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic w,
                        input logic [4:0] wa, input logic [31:0] wd, input logic wh,
                        input logic [31:0] h, input logic [31:0] l, input logic [31:0] rd,
                        input int delay);
    bit ld, st, sgn, ll, sc, mis, scfail, use_bus;
    int sz, off, shamt;
    logic [31:0] mask, raw, exp_sel, exp_bwd, exp_wdata;
    logic exp_we, exp_wh, exp_err;
    ld = 0; st = 0; sgn = 0; ll = 0; sc = 0; sz = 4;
    case (op)
      4'd1: begin ld = 1; sgn = 1; sz = 1; end
      4'd2: begin ld = 1; sz = 1; end
      4'd3: begin ld = 1; sgn = 1; sz = 2; end
      4'd4: begin ld = 1; sz = 2; end
      4'd5: ld = 1;
      4'd6: begin st = 1; sz = 1; end
      4'd7: begin st = 1; sz = 2; end
      4'd8: st = 1;
      4'd9: begin ld = LlscEn; ll = LlscEn; end
      4'd10: begin st = LlscEn; sc = LlscEn; end
      default: ;
    endcase
    off     = int'(addr % 4);
    mis     = (ld || st) && (addr % sz != 0);
    scfail  = sc && !llbit_m && !mis;
    use_bus = (ld || st) && !mis && !scfail;
    exp_sel = (sz == 1) ? (32'h8 >> off) : (sz == 2) ? (32'hC >> off) : 32'hF;
    exp_bwd = (sz == 1) ? wd[7:0] * 32'h01010101 : (sz == 2) ? wd[15:0] * 32'h00010001 : wd;
    shamt   = 8 * (4 - sz - off);
    mask    = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
    raw     = (rd >> shamt) & mask;
    if (sgn && ((raw >> (8 * sz - 1)) & 32'd1) == 32'd1) raw = raw | ~mask;

    exp_err = mis;
    exp_we  = mis ? 1'b0 : (st && !sc) ? 1'b0 : w;
    exp_wh  = mis ? 1'b0 : wh;
    exp_wdata = ld ? raw : sc ? (scfail ? 32'd0 : 32'd1) : wd;

    mem_op = op; mem_addr = addr; we = w; waddr = wa; wdata = wd;
    we_hilo = wh; hi = h; lo = l; bus_rdata = rd; bus_ack = 1'b0;
    if (!use_bus) bus_ack = 1'($urandom_range(0, 1));
    #1;
    if (!use_bus) begin
      check("idle_req", bus_req, 0);
      check("idle_stall", stall_req, 0);
    end else begin
      check("req_start", bus_req, 1);
      check("stall_start", stall_req, 1);
      check("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
      check("bus_sel", bus_sel, exp_sel);
      check("bus_we", bus_we, st);
      if (st) check("bus_wdata", bus_wdata, exp_bwd);
      for (int i = 0; i <= delay; i++) begin
        @(posedge clk); #1;
        check("req_busy", bus_req, 1);
        check("stall_busy", stall_req, 1);
        check("bubble_we", we_o, 0);
        check("bubble_hilo", we_hilo_o, 0);
        check("busy_sel", bus_sel, exp_sel);
      end
      bus_ack = 1'b1;
      #1;
      check("stall_ack", stall_req, 0);
      check("req_ack", bus_req, 1);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    check("we_o", we_o, exp_we);
    check("we_hilo_o", we_hilo_o, exp_wh);
    check("addr_err", addr_err, exp_err);
    if (exp_we) begin
      check("waddr_o", waddr_o, wa);
      check("wdata_o", wdata_o, exp_wdata);
    end
    if (exp_wh) begin
      check("hi_o", hi_o, h);
      check("lo_o", lo_o, l);
    end
    if (use_bus && ll) llbit_m = 1'b1;
    if (use_bus && st) llbit_m = 1'b0;
  endtask

  initial begin
    rst = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'hDEAD_BEEF; mem_op = 4'd5;
    mem_addr = 32'h100; we_hilo = 1'b1; hi = 32'h1; lo = 32'h2;
    bus_rdata = 32'h0; bus_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", bus_req, 0);
    check("rst_stall", stall_req, 0);
    check("rst_we_o", we_o, 0);
    check("rst_wdata_o", wdata_o, 0);
    check("rst_hilo", we_hilo_o, 0);
    check("rst_err", addr_err, 0);
    mem_op = 4'd0;
    #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(4'd0, 32'h0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 32'h0, 0);
    run_op(4'd1, 32'h1001, 1'b1, 5'd7, 32'h0, 1'b0, 32'h0, 32'h0, 32'h11AA_2233, 1);
    run_op(4'd4, 32'h2002, 1'b1, 5'd8, 32'h0, 1'b1, 32'hAAAA, 32'hBBBB, 32'h0000_BEEF, 0);
    run_op(4'd7, 32'h10, 1'b1, 5'd9, 32'h0000_ABCD, 1'b0, 32'h0, 32'h0, 32'h0, 0);
    run_op(4'd5, 32'h103, 1'b1, 5'd10, 32'h5, 1'b1, 32'h3, 32'h4, 32'h0, 0);
    run_op(4'd0, 32'h0, 1'b1, 5'd11, 32'h6, 1'b0, 32'h0, 32'h0, 32'h0, 0);
    run_op(4'd6, 32'h23, 1'b0, 5'd1, 32'h0000_0077, 1'b0, 32'h0, 32'h0, 32'h0, 2);
    run_op(4'd3, 32'h01, 1'b1, 5'd2, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 0);
    run_op(4'd9, 32'h40, 1'b1, 5'd12, 32'h99, 1'b0, 32'h0, 32'h0, 32'h8000_0001, 0);
    run_op(4'd10, 32'h40, 1'b1, 5'd13, 32'h55, 1'b0, 32'h0, 32'h0, 32'h0, 1);
    run_op(4'd10, 32'h40, 1'b1, 5'd13, 32'h55, 1'b0, 32'h0, 32'h0, 32'h0, 0);

    // Reset while a load is outstanding, then a late ack must be ignored.
    mem_op = 4'd5; mem_addr = 32'h80; we = 1'b1; waddr = 5'd4; wdata = 32'h1;
    #1;
    check("mid_req", bus_req, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_req", bus_req, 0);
    check("mid_rst_stall", stall_req, 0);
    @(posedge clk); #1;
    check("mid_rst_we_o", we_o, 0);
    check("mid_rst_waddr", waddr_o, 0);
    check("mid_rst_wdata", wdata_o, 0);
    check("mid_rst_hi", hi_o, 0);
    rst = 1'b1; mem_op = 4'd0; we = 1'b0; bus_ack = 1'b1;
    #1;
    check("late_ack_req", bus_req, 0);
    check("late_ack_stall", stall_req, 0);
    @(posedge clk); #1;
    check("late_ack_we_o", we_o, 0);
    bus_ack = 1'b0;
    llbit_m = 1'b0;

    for (int n = 0; n < 300; n++) begin
      logic [3:0] op;
      logic [31:0] addr;
      op   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15))
                                          : 4'($urandom_range(0, 10));
      addr = {$urandom_range(0, 255) * 32'd16, 4'h0} | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) addr = addr & 32'hFFFF_FFFC;
      if (op == 4'd9 || op == 4'd10) addr = 32'h40;
      run_op(op, addr, 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
             1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stage_mem.md
Name: stage_mem

Overview:
- Memory-access pipeline stage directly downstream of the execute stage.
- Consumes EX results (register write, HI/LO write, load/store request) and runs a req/ack handshake with the data bus for loads and stores.
- Drives the write-back stage through registered outputs, so it also acts as the MEM/WB pipeline register.
- Requests a pipeline stall while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, data bus address width.
- MEMOP_W, 4, width of the mem_op code.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- we  in  1  EX register-file write enable.
- waddr  in  5  EX destination register.
- wdata  in  32  EX result; store data source.
- mem_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC; other codes are treated as NONE.
- mem_addr  in  ADDR_W  effective byte address.
- we_hilo  in  1  HI/LO write enable.
- hi  in  32  HI value.
- lo  in  32  LO value.
- we_o  out  1  WB register write enable.
- waddr_o  out  5  WB destination register.
- wdata_o  out  32  WB data.
- we_hilo_o  out  1  WB HI/LO write enable.
- hi_o  out  32  WB HI value.
- lo_o  out  32  WB LO value.
- stall_req  out  1  freeze upstream pipeline; combinational.
- addr_err  out  1  registered misalignment flag for one cycle.
- bus_req  out  1  bus transaction request.
- bus_we  out  1  1 = store.
- bus_addr  out  ADDR_W  word address; low two bits are forced to 0.
- bus_sel  out  4  byte-lane enables, big-endian.
- bus_wdata  out  32  store data, replicated to the addressed lanes.
- bus_rdata  in  32  load data.
- bus_ack  in  1  transaction complete.

Behaviour:
- Reset (rst=0 at a clock edge):
  - Every registered output goes to 0: we_o, waddr_o, wdata_o, we_hilo_o, hi_o, lo_o, addr_err.
  - FSM goes to IDLE.
  - Combinational outputs are 0 while rst=0: bus_req, stall_req.
  - Reset mid-transaction abandons the transaction. Any late bus_ack is ignored.
- FSM states and transitions:
  - IDLE: mem_op NONE passes all inputs to the outputs at the next edge (1-cycle latency). A valid, aligned mem_op moves to BUSY in the same cycle: bus_req=1 combinationally and stall_req=1.
  - BUSY: bus_req held at 1, bus signals stable. Inputs are guaranteed stable by the stall.
  - bus_ack=1 in BUSY: stall_req=0 in that same cycle. At that edge the result is registered and the FSM returns to IDLE.
  - A back-to-back memory op is accepted in the following cycle.
  - While stalled, the registered outputs carry a bubble (all enables 0).
- Alignment and errors:
  - Halfword requires addr[0]=0. Word (LW, SW, LL, SC) requires addr[1:0]=0.
  - Misaligned: no bus request, no stall; next edge we_o=0, we_hilo_o=0, addr_err=1.
- Lane selection, big-endian:
  - Byte: offset 0 → sel 1000 (bits 31:24), offset 3 → 0001.
  - Halfword: offset 0 → 1100, offset 2 → 0011.
  - Word: 1111.
- Load extraction:
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - Loads write wdata_o with the extracted value and we_o=we.
  - Stores: we_o=0.
- HI/LO pass through unchanged for all ops.
- Simultaneous events:
  - bus_ack in IDLE is ignored.
  - bus_ack is sampled only when bus_req=1.
  - No timeout: the stall lasts until ack.

Optional Feature:
- Macro: STAGE_MEM_LLSC_EN.
- Defined:
  - Internal llbit register, reset 0.
  - LL behaves as LW and sets llbit=1 at ack.
  - SC with llbit=1 performs SW, then writes 1 to rd (we_o=we) and clears llbit.
  - SC with llbit=0 issues no bus request and no stall; it writes 0 to rd next edge.
  - Any completed SW/SH/SB clears llbit.
- Undefined:
  - Codes 9 and 10 are treated as NONE; no llbit exists.

Test Plan:
- Reset and pass-through: rst=0 then 1; mem_op=0, we=1, waddr=5, wdata=0x12345678 → next cycle we_o=1, waddr_o=5, wdata_o=0x12345678, stall_req=0 throughout.
- LB sign-extend: LB addr=0x1001, bus_rdata=0x11AA2233, ack after 3 cycles → bus_sel=0100 and bus_addr=0x1000 held 3 cycles, stall_req=1 until the ack cycle, then wdata_o=0xFFFFFFAA.
- LHU: addr=0x2002, rdata=0x0000BEEF, immediate ack → wdata_o=0x0000BEEF, bus_sel=0011.
- Store lanes: SH wdata=0x0000ABCD addr=0x10 → bus_we=1, sel=1100, bus_wdata=0xABCDABCD, we_o=0.
- Misaligned: LW addr=0x103 → bus_req never asserts, addr_err=1 for one cycle, we_o=0.
- LL/SC with STAGE_MEM_LLSC_EN:
  - LL 0x40, then SC 0x40 → SC stores, wdata_o=1.
  - Repeat the SC → no bus_req, wdata_o=0.
- Reset during BUSY: rst=0 while bus_req=1 → bus_req=0 and stall_req=0 immediately; outputs are 0 after the edge.
